// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared scoreboard types and helpers for hazard_fwd_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Slot fields are sized for the widest supported configuration.
    // Narrower register/Tnew widths are zero-extended into them.
    localparam int RA_W_MAX   = 8;
    localparam int TNEW_W_MAX = 4;
    localparam int MULT_CYC   = 5;
    localparam int DIV_CYC    = 10;

    typedef struct packed {
        logic [RA_W_MAX-1:0]   a3;
        logic [TNEW_W_MAX-1:0] tnew;
        logic [RA_W_MAX-1:0]   rs;
        logic [RA_W_MAX-1:0]   rt;
        logic                  md_start;
        logic                  md_div;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    function automatic logic [TNEW_W_MAX-1:0] sat_dec(input logic [TNEW_W_MAX-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W_MAX'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// fwd_sel : youngest-first forwarding selector over up to N_CAND producers
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_sel #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int TNEW_W = 2,
    parameter int N_CAND = 3
) (
    input  logic [RA_W-1:0]               i_src,
    input  logic [DATA_W-1:0]             i_own,
    input  logic [N_CAND-1:0][RA_W-1:0]   i_a3,
    input  logic [N_CAND-1:0][TNEW_W-1:0] i_tnew,
    input  logic [N_CAND-1:0][DATA_W-1:0] i_wd,
    input  logic [N_CAND-1:0]             i_en,
    output logic [DATA_W-1:0]             o_val,
    output logic                          o_blocked
);

    logic w_hit;

    // Index 0 is the youngest candidate; the first match decides alone.
    always_comb begin
        o_val     = i_own;
        o_blocked = 1'b0;
        w_hit     = 1'b0;
        for (int i = 0; i < N_CAND; i++) begin
            if (!w_hit && i_en[i] && (i_src != '0) && (i_src == i_a3[i])) begin
                w_hit = 1'b1;
                if (i_tnew[i] == '0) begin
                    o_val = i_wd[i];
                end else begin
                    o_blocked = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// hazard_fwd_ctrl : E/M/W scoreboard, Tuse/Tnew forwarding and stall, mult/div busy
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl #(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int TNEW_W   = 2,
    parameter int MULT_CYC = hazard_pkg::MULT_CYC,
    parameter int DIV_CYC  = hazard_pkg::DIV_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RA_W-1:0]   d_rs,
    input  logic [RA_W-1:0]   d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [RA_W-1:0]   d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] e_rs_val,
    input  logic [DATA_W-1:0] e_rt_val,
    input  logic [DATA_W-1:0] m_rt_val,
    input  logic [DATA_W-1:0] wd_e,
    input  logic [DATA_W-1:0] wd_m,
    input  logic [DATA_W-1:0] wd_w,
    output logic [DATA_W-1:0] d_rs_fwd,
    output logic [DATA_W-1:0] d_rt_fwd,
    output logic [DATA_W-1:0] e_rs_fwd,
    output logic [DATA_W-1:0] e_rt_fwd,
    output logic [DATA_W-1:0] m_rt_fwd,
    output logic              stall,
    output logic              md_busy
);

    import hazard_pkg::*;

    localparam int c_cyc_max = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int c_cnt_w   = $clog2(c_cyc_max + 1);

    slot_t               r_slot_e;
    slot_t               r_slot_m;
    slot_t               r_slot_w;
    slot_t               w_slot_d;
    logic [c_cnt_w-1:0]  r_md_cnt;

    logic w_stall_rs, w_stall_rt, w_data_stall, w_md_stall, w_md_busy;
    logic w_blk_d_rs, w_blk_d_rt, w_blk_e_rs, w_blk_e_rt, w_blk_m_rt;
    logic w_unused_bits;

    function automatic slot_t age(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = sat_dec(s.tnew);
        return r;
    endfunction

    // Stored M.tnew already carries one decrement, so both slots compare directly.
    function automatic logic src_stall(input logic en, input logic [RA_W_MAX-1:0] r,
                                       input logic [TNEW_W_MAX-1:0] tuse,
                                       input slot_t e, input slot_t m);
        if (!en || r == '0) return 1'b0;
        if (r == e.a3)      return e.tnew > tuse;
        if (r == m.a3)      return m.tnew > tuse;
        return 1'b0;
    endfunction

    always_comb begin
        w_slot_d          = BUBBLE;
        w_slot_d.a3       = RA_W_MAX'(d_a3);
        w_slot_d.tnew     = TNEW_W_MAX'(d_tnew);
        w_slot_d.rs       = RA_W_MAX'(d_rs);
        w_slot_d.rt       = RA_W_MAX'(d_rt);
        w_slot_d.md_start = d_md_start;
        w_slot_d.md_div   = d_md_div;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_e <= BUBBLE;
            r_slot_m <= BUBBLE;
            r_slot_w <= BUBBLE;
            r_md_cnt <= '0;
        end else begin
            r_slot_e <= stall ? BUBBLE : w_slot_d;
            r_slot_m <= age(r_slot_e);
            r_slot_w <= age(r_slot_m);
            if (r_slot_e.md_start) begin
                r_md_cnt <= r_slot_e.md_div ? c_cnt_w'(DIV_CYC) : c_cnt_w'(MULT_CYC);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - c_cnt_w'(1);
            end
        end
    end

    assign w_stall_rs   = src_stall(d_use_rs, RA_W_MAX'(d_rs), TNEW_W_MAX'(d_tuse_rs), r_slot_e, r_slot_m);
    assign w_stall_rt   = src_stall(d_use_rt, RA_W_MAX'(d_rt), TNEW_W_MAX'(d_tuse_rt), r_slot_e, r_slot_m);
    assign w_data_stall = w_stall_rs | w_stall_rt;
    assign w_md_busy    = (r_md_cnt != '0) | r_slot_e.md_start;
    assign w_md_stall   = d_md_use & w_md_busy;
    assign stall        = w_data_stall | w_md_stall;
    assign md_busy      = w_md_busy;

    fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W_MAX), .TNEW_W(TNEW_W_MAX), .N_CAND(3)) u_fwd_d_rs (
        .i_src     (RA_W_MAX'(d_rs)),
        .i_own     (rd1),
        .i_a3      ({r_slot_w.a3,   r_slot_m.a3,   r_slot_e.a3}),
        .i_tnew    ({r_slot_w.tnew, r_slot_m.tnew, r_slot_e.tnew}),
        .i_wd      ({wd_w, wd_m, wd_e}),
        .i_en      (3'b111),
        .o_val     (d_rs_fwd),
        .o_blocked (w_blk_d_rs)
    );

    fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W_MAX), .TNEW_W(TNEW_W_MAX), .N_CAND(3)) u_fwd_d_rt (
        .i_src     (RA_W_MAX'(d_rt)),
        .i_own     (rd2),
        .i_a3      ({r_slot_w.a3,   r_slot_m.a3,   r_slot_e.a3}),
        .i_tnew    ({r_slot_w.tnew, r_slot_m.tnew, r_slot_e.tnew}),
        .i_wd      ({wd_w, wd_m, wd_e}),
        .i_en      (3'b111),
        .o_val     (d_rt_fwd),
        .o_blocked (w_blk_d_rt)
    );

    fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W_MAX), .TNEW_W(TNEW_W_MAX), .N_CAND(3)) u_fwd_e_rs (
        .i_src     (r_slot_e.rs),
        .i_own     (e_rs_val),
        .i_a3      ({r_slot_w.a3,   r_slot_w.a3,   r_slot_m.a3}),
        .i_tnew    ({r_slot_w.tnew, r_slot_w.tnew, r_slot_m.tnew}),
        .i_wd      ({wd_w, wd_w, wd_m}),
        .i_en      (3'b011),
        .o_val     (e_rs_fwd),
        .o_blocked (w_blk_e_rs)
    );

    fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W_MAX), .TNEW_W(TNEW_W_MAX), .N_CAND(3)) u_fwd_e_rt (
        .i_src     (r_slot_e.rt),
        .i_own     (e_rt_val),
        .i_a3      ({r_slot_w.a3,   r_slot_w.a3,   r_slot_m.a3}),
        .i_tnew    ({r_slot_w.tnew, r_slot_w.tnew, r_slot_m.tnew}),
        .i_wd      ({wd_w, wd_w, wd_m}),
        .i_en      (3'b011),
        .o_val     (e_rt_fwd),
        .o_blocked (w_blk_e_rt)
    );

    fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W_MAX), .TNEW_W(TNEW_W_MAX), .N_CAND(3)) u_fwd_m_rt (
        .i_src     (r_slot_m.rt),
        .i_own     (m_rt_val),
        .i_a3      ({r_slot_w.a3,   r_slot_w.a3,   r_slot_w.a3}),
        .i_tnew    ({r_slot_w.tnew, r_slot_w.tnew, r_slot_w.tnew}),
        .i_wd      ({wd_w, wd_w, wd_w}),
        .i_en      (3'b001),
        .o_val     (m_rt_fwd),
        .o_blocked (w_blk_m_rt)
    );

    // Blocked flags only matter to downstream debug; operand fields retire unused.
    assign w_unused_bits = ^{w_blk_d_rs, w_blk_d_rt, w_blk_e_rs, w_blk_e_rt, w_blk_m_rt,
                             r_slot_m.rs, r_slot_m.md_start, r_slot_m.md_div,
                             r_slot_w.rs, r_slot_w.rt, r_slot_w.md_start, r_slot_w.md_div};

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
// tb_hazard_fwd_ctrl : directed self-checking bench for hazard_fwd_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int TNEW_W = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [RA_W-1:0]   d_rs, d_rt, d_a3;
    logic              d_use_rs, d_use_rt;
    logic [TNEW_W-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic              d_md_use, d_md_start, d_md_div;
    logic [DATA_W-1:0] rd1, rd2, e_rs_val, e_rt_val, m_rt_val, wd_e, wd_m, wd_w;
    logic [DATA_W-1:0] d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, m_rt_fwd;
    logic              stall, md_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;
    int n_gap;

    hazard_fwd_ctrl #(.DATA_W(DATA_W), .RA_W(RA_W), .TNEW_W(TNEW_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .rd1(rd1), .rd2(rd2), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .m_rt_val(m_rt_val),
        .wd_e(wd_e), .wd_m(wd_m), .wd_w(wd_w),
        .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd), .e_rs_fwd(e_rs_fwd),
        .e_rt_fwd(e_rt_fwd), .m_rt_fwd(m_rt_fwd),
        .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int rs, input int rt, input bit urs, input bit urt,
                         input int tuse, input int a3, input int tnew,
                         input bit md_use, input bit md_start, input bit md_div);
        d_rs       = RA_W'(rs);
        d_rt       = RA_W'(rt);
        d_use_rs   = urs;
        d_use_rt   = urt;
        d_tuse_rs  = TNEW_W'(tuse);
        d_tuse_rt  = TNEW_W'(tuse);
        d_a3       = RA_W'(a3);
        d_tnew     = TNEW_W'(tnew);
        d_md_use   = md_use;
        d_md_start = md_start;
        d_md_div   = md_div;
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        rd1      = 32'h000000A1;
        rd2      = 32'h000000A2;
        e_rs_val = 32'h000000B1;
        e_rt_val = 32'h000000B2;
        m_rt_val = 32'h000000C2;
        wd_e     = 32'h00000011;
        wd_m     = 32'h00000022;
        wd_w     = 32'h00000033;
        nop();
        #1;
        chk("rst_stall",  {31'd0, stall},   32'd0);
        chk("rst_busy",   {31'd0, md_busy}, 32'd0);
        chk("rst_d_rs",   d_rs_fwd, 32'h000000A1);
        chk("rst_d_rt",   d_rt_fwd, 32'h000000A2);
        chk("rst_e_rs",   e_rs_fwd, 32'h000000B1);
        chk("rst_e_rt",   e_rt_fwd, 32'h000000B2);
        chk("rst_m_rt",   m_rt_fwd, 32'h000000C2);
        tick();
        reset_n = 1'b1;
        tick();

        // addu $1,$2,$3 -> addu $4,$1,$1
        set_d(2, 3, 1, 1, 1, 1, 1, 0, 0, 0);
        tick();
        set_d(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
        chk("addu_nostall", {31'd0, stall}, 32'd0);
        chk("addu_d_blocked", d_rs_fwd, 32'h000000A1);
        tick();
        wd_m = 32'h00000005;
        nop();
        chk("addu_e_rs", e_rs_fwd, 32'h00000005);
        chk("addu_e_rt", e_rt_fwd, 32'h00000005);
        tick();
        wd_m = 32'h00000022;
        #1;
        chk("addu_m_rt_w", m_rt_fwd, 32'h00000033);
        drain();

        // lw $1 -> beq $1,$0
        set_d(2, 0, 1, 0, 1, 1, 2, 0, 0, 0);
        tick();
        set_d(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        wd_w = 32'hDEADBEEF;
        #1;
        n_cyc = 0;
        while (stall && n_cyc < 10) begin
            n_cyc++;
            tick();
        end
        chk("lw_stall_cycles", n_cyc, 32'd2);
        chk("lw_d_rs_w", d_rs_fwd, 32'hDEADBEEF);
        tick();
        wd_w = 32'h00000033;
        drain();

        // youngest-priority: $8 produced in E and M
        set_d(0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        tick();
        set_d(8, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("prio_d_rs_e", d_rs_fwd, 32'h00000011);
        chk("prio_nostall", {31'd0, stall}, 32'd0);
        tick();
        chk("prio_d_rs_m", d_rs_fwd, 32'h00000022);
        chk("prio_e_rs_m", e_rs_fwd, 32'h00000022);
        drain();

        // $0 destination never forwards
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        wd_e = 32'hFFFFFFFF;
        set_d(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_d_rs", d_rs_fwd, 32'h000000A1);
        chk("zero_nostall", {31'd0, stall}, 32'd0);
        wd_e = 32'h00000011;
        drain();

        // div -> mfhi, then mult -> mfhi
        for (int k = 0; k < 2; k++) begin
            set_d(2, 3, 1, 1, 1, 0, 0, 1, 1, (k == 0));
            chk("md_start_busy0", {31'd0, md_busy}, 32'd0);
            chk("md_start_nostall", {31'd0, stall}, 32'd0);
            tick();
            set_d(0, 0, 0, 0, 0, 5, 1, 1, 0, 0);
            n_cyc = 0;
            n_gap = 0;
            while (md_busy && n_cyc < 50) begin
                if (!stall) n_gap++;
                n_cyc++;
                tick();
            end
            chk(k == 0 ? "div_busy_cycles" : "mult_busy_cycles", n_cyc, (k == 0) ? 32'd11 : 32'd6);
            chk("md_stall_held", n_gap, 32'd0);
            chk("md_issue_nostall", {31'd0, stall}, 32'd0);
            tick();
            drain();
        end

        // reset pulsed mid-stall
        set_d(2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        tick();
        set_d(2, 3, 1, 1, 1, 0, 0, 1, 1, 1);
        tick();
        set_d(1, 0, 1, 0, 1, 6, 1, 1, 0, 0);
        chk("rstmid_stall_pre", {31'd0, stall}, 32'd1);
        chk("rstmid_d_rs_pre", d_rs_fwd, 32'h00000022);
        reset_n = 1'b0;
        #1;
        chk("rstmid_stall", {31'd0, stall},   32'd0);
        chk("rstmid_busy",  {31'd0, md_busy}, 32'd0);
        chk("rstmid_d_rs",  d_rs_fwd, 32'h000000A1);
        chk("rstmid_d_rt",  d_rt_fwd, 32'h000000A2);
        chk("rstmid_e_rs",  e_rs_fwd, 32'h000000B1);
        chk("rstmid_m_rt",  m_rt_fwd, 32'h000000C2);
        reset_n = 1'b1;
        tick();
        nop();
        chk("rstmid_busy_after", {31'd0, md_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
